fifo_uart_tx: RTL and testbench
===============================

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the width of one FIFO word and of the serial payload.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 4, giving the number of clk cycles per serial bit, legal values >= 2.
REQ-003 The block SHALL have port clk  input  1  single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port tx_en  input  1  when high, permits a new frame to start.
REQ-006 The block SHALL have port fifo_empty  input  1  empty flag of the upstream FIFO.
REQ-007 The block SHALL have port fifo_data  input  DATA_WIDTH  combinational head-of-FIFO word, valid while fifo_empty=0.
REQ-008 The block SHALL have port fifo_read  output  1  registered one-cycle pop strobe to the FIFO.
REQ-009 The block SHALL have port tx  output  1  registered serial line, idle high.
REQ-010 The block SHALL have port busy  output  1  registered, high while a frame is being transmitted.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY exists only per REQ-026.
REQ-012 In IDLE with tx_en=1 and fifo_empty=0 at a clk edge, the block SHALL load fifo_data into the shift register, drive fifo_read=1 for exactly the following cycle, set busy=1 and enter START.
REQ-013 fifo_read SHALL never be high for more than one consecutive cycle and SHALL never assert while fifo_empty=1 was sampled.
REQ-014 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-015 DATA SHALL drive DATA_WIDTH bits LSB first, each held for CLKS_PER_BIT cycles, with a bit counter of width $clog2(DATA_WIDTH) that wraps to 0 on leaving DATA.
REQ-016 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; on its last cycle the FSM SHALL return to IDLE and busy SHALL clear.
REQ-017 The baud counter SHALL count 0..CLKS_PER_BIT-1, reload to 0 on each bit boundary, and never overflow.
REQ-018 Back-to-back frames SHALL have exactly one IDLE cycle (tx=1, busy=0) between the STOP end and the next START.
REQ-019 Deasserting tx_en mid-frame SHALL NOT abort the frame; it SHALL only block the next start.
REQ-020 Changes on fifo_data or fifo_empty after the load cycle SHALL NOT affect the frame in progress.
REQ-021 tx SHALL be glitch-free, as a direct register output.

Reset
REQ-022 On rstn=0, the block SHALL immediately, without waiting for clk, set the state to IDLE, tx=1, busy=0, fifo_read=0, and clear the counters and shift register.
REQ-023 Reset mid-frame SHALL abandon the frame without popping another word; a word already popped is lost.
REQ-024 After rstn rises, the first start SHALL occur no earlier than the first clk edge with tx_en=1 and fifo_empty=0.

Configuration
REQ-025 The block SHALL have a macro TX_PARITY_EN.
REQ-026 With TX_PARITY_EN defined, a PARITY state SHALL follow DATA, driving the even-parity bit (XOR of the payload) for CLKS_PER_BIT cycles; a frame SHALL be (DATA_WIDTH+3)*CLKS_PER_BIT cycles.
REQ-027 Without TX_PARITY_EN, DATA SHALL go directly to STOP, no parity logic SHALL exist, and a frame SHALL be (DATA_WIDTH+2)*CLKS_PER_BIT cycles.

Verification
REQ-028 Single byte, defaults, no parity: FIFO holds 0xA5 and tx_en=1 -> one fifo_read pulse; tx = 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles; busy high 40 cycles.
REQ-029 Parity build: byte 0xA5 -> parity bit 0, frame 44 cycles; byte 0x01 -> parity bit 1.
REQ-030 Back-to-back: FIFO holds 0x00 then 0xFF -> two fifo_read pulses 41 cycles apart, exactly one idle-high cycle between frames, and fifo_empty=1 afterwards with no further pulses.
REQ-031 Empty or disabled: fifo_empty=1 or tx_en=0 for 100 cycles -> tx=1, busy=0, fifo_read=0 throughout; tx_en dropped at cycle 10 of a frame -> frame completes and no next start.
REQ-032 Reset mid-frame: rstn=0 at cycle 17 of a frame -> tx=1 and busy=0 before the next clk edge; after release with the FIFO non-empty -> a new complete frame.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one word per frame, sends start/data LSB-first/stop; TX_PARITY_EN adds even parity.
// Registered outputs, start edge to first tx=0 is one clk; the FIFO is only popped from IDLE, so an empty FIFO or tx_en=0 simply holds the line idle.
module fifo_uart_tx #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_read,
   output logic                  tx,
   output logic                  busy
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef TX_PARITY_EN
      PARITY = 3'd4,
`endif
      STOP   = 3'd3
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         baud_q, baud_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  fifo_read_q, fifo_read_d;
`ifdef TX_PARITY_EN
   logic                  parity_q, parity_d;
`endif

   logic baud_end;
   logic bit_end;
   logic load;

   assign baud_end = (baud_q == BAUD_LAST);
   assign bit_end  = (bit_q == BIT_LAST);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         tx_q        <= 1'b1;
         busy_q      <= 1'b0;
         fifo_read_q <= 1'b0;
`ifdef TX_PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         tx_q        <= tx_d;
         busy_q      <= busy_d;
         fifo_read_q <= fifo_read_d;
`ifdef TX_PARITY_EN
         parity_q    <= parity_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (tx_en && !fifo_empty) state_d = START;
         end
         START: begin
            if (baud_end) state_d = DATA;
         end
         DATA: begin
            if (baud_end && bit_end) begin
`ifdef TX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
`ifdef TX_PARITY_EN
         PARITY: begin
            if (baud_end) state_d = STOP;
         end
`endif
         STOP: begin
            if (baud_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed from the next state so tx/busy change on the same edge as the FSM.
   always_comb begin
      load        = (state_q == IDLE) && (state_d == START);
      fifo_read_d = load;
      busy_d      = (state_d != IDLE);

      baud_d = '0;
      if (state_q != IDLE && !baud_end) baud_d = baud_q + 1'b1;

      bit_d = bit_q;
      if (state_q == DATA && baud_end) bit_d = bit_end ? '0 : bit_q + 1'b1;

      shift_d = shift_q;
      if (load) shift_d = fifo_data;
      else if (state_q == DATA && baud_end) shift_d = shift_q >> 1;

`ifdef TX_PARITY_EN
      parity_d = parity_q;
      if (load) parity_d = ^fifo_data;
`endif

      tx_d = 1'b1;
      case (state_d)
         START:  tx_d = 1'b0;
         DATA:   tx_d = shift_d[0];
`ifdef TX_PARITY_EN
         PARITY: tx_d = parity_q;
`endif
         default: tx_d = 1'b1;
      endcase
   end

   assign fifo_read = fifo_read_q;
   assign tx        = tx_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a small FIFO model and hand-derived serial frames.
module tb_fifo_uart_tx;

   localparam int CPB = 4;
`ifdef TX_PARITY_EN
   localparam int FRAME = (8 + 3) * CPB;
`else
   localparam int FRAME = (8 + 2) * CPB;
`endif

   logic       clk = 1'b0;
   logic       rstn = 1'b1;
   logic       tx_en = 1'b0;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_read;
   logic       tx;
   logic       busy;

   logic [7:0] mem [0:15];
   logic [3:0] wr_ptr = '0;
   logic [3:0] rd_ptr = '0;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int bad_pop = 0;
   int dbl_pulse = 0;
   int cyc = 0;
   int last_cyc = 0;
   int gap = 0;
   logic prev_rd = 1'b0;

   assign fifo_empty = (rd_ptr == wr_ptr);
   assign fifo_data  = mem[rd_ptr];

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .tx_en      (tx_en),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_read  (fifo_read),
      .tx         (tx),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // FIFO model: pops on the edge that samples fifo_read, and tracks pulse spacing.
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      prev_rd <= fifo_read;
      if (fifo_read === 1'b1) begin
         if (!fifo_empty) rd_ptr <= rd_ptr + 4'd1;
         else bad_pop <= bad_pop + 1;
         if (prev_rd === 1'b1) dbl_pulse <= dbl_pulse + 1;
         pulses   <= pulses + 1;
         gap      <= cyc - last_cyc;
         last_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 4'd1;
   endtask

   function automatic logic exp_tx(input logic [7:0] b, input int i);
      int k;
      k = i / CPB;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   task automatic idle_window(input int ncyc, input string tag);
      int bad = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_read !== 1'b0) bad++;
      end
      check(tag, bad, 0);
   endtask

   // Waits (bounded) for a frame to start, then checks every cycle of it.
   task automatic run_frame(input logic [7:0] b, input string tag, input int drop_at,
                            input int rst_at, output int waited);
      int n = 0;
      int rd_cnt = 0;
      do begin
         @(negedge clk);
         n++;
         if (busy !== 1'b1) check({tag, "_idle_line"}, {30'd0, tx, fifo_read}, 32'd2);
      end while (busy !== 1'b1 && n < 64);
      waited = n;
      check({tag, "_started"}, busy, 1);
      if (busy !== 1'b1) return;
      for (int i = 0; i < FRAME; i++) begin
         if (i > 0) @(negedge clk);
         if (i == drop_at) tx_en = 1'b0;
         check($sformatf("%s_tx_c%0d", tag, i), tx, exp_tx(b, i));
         check($sformatf("%s_busy_c%0d", tag, i), busy, 1);
         if (fifo_read === 1'b1) rd_cnt++;
         if (i == 0) check({tag, "_pop_first"}, fifo_read, 1);
         if (i == rst_at) begin
            rstn = 1'b0;
            #1;
            check({tag, "_rst_tx"}, tx, 1);
            check({tag, "_rst_busy"}, busy, 0);
            check({tag, "_rst_rd"}, fifo_read, 0);
            return;
         end
      end
      check({tag, "_pop_count"}, rd_cnt, 1);
   endtask

   initial begin
      int w;
      #1 rstn = 1'b0;
      #1;
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_rd", fifo_read, 0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      idle_window(3, "post_reset_idle");

      // Single word 0xA5, then an empty FIFO with tx_en held high.
      push(8'hA5);
      tx_en = 1'b1;
      run_frame(8'hA5, "a5", -1, -1, w);
      idle_window(100, "empty_idle");
      check("pulses_a5", pulses, 1);

      push(8'h01);
      run_frame(8'h01, "w01", -1, -1, w);
      check("pulses_01", pulses, 2);

      // Back-to-back: exactly one idle cycle between frames.
      push(8'h00);
      push(8'hFF);
      run_frame(8'h00, "b2b_00", -1, -1, w);
      run_frame(8'hFF, "b2b_ff", -1, -1, w);
      check("b2b_wait", w, 2);
      check("b2b_gap", gap, FRAME + 1);
      idle_window(100, "b2b_after");
      check("pulses_b2b", pulses, 4);
      check("b2b_fifo_empty", fifo_empty, 1);

      // Disabled with data waiting.
      tx_en = 1'b0;
      push(8'h3C);
      push(8'h52);
      idle_window(100, "disabled_idle");
      check("pulses_disabled", pulses, 4);

      // tx_en dropped mid-frame: frame completes, no next start.
      tx_en = 1'b1;
      run_frame(8'h3C, "drop", 10, -1, w);
      idle_window(30, "drop_after");
      check("pulses_drop", pulses, 5);
      check("drop_fifo_nonempty", fifo_empty, 0);

      // Reset mid-frame at cycle 17 (tx low there), then a fresh frame.
      tx_en = 1'b1;
      run_frame(8'h52, "rstmid", -1, 17, w);
      push(8'h96);
      @(negedge clk);
      @(negedge clk);
      check("rst_hold_busy", busy, 0);
      check("pulses_rstmid", pulses, 6);
      rstn = 1'b1;
      run_frame(8'h96, "after_rst", -1, -1, w);
      idle_window(5, "final_idle");
      check("pulses_final", pulses, 7);
      check("final_fifo_empty", fifo_empty, 1);
      check("pop_while_empty", bad_pop, 0);
      check("double_pulse", dbl_pulse, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
